pipeline_fetch: RTL

PIPELINE_FETCH -- requirements
Module: pipeline_fetch

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/pipeline_fetch.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, reset PC, fetch FSM states and the queued fetch record.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_INIT = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of fetched {instr, pc4}; head visible the cycle after a push.
// Push is dropped when full unless a pop frees the slot; flush wins over push and pop.
module fetch_queue
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_vld,
    output fetch_entry_t head_dat
);

    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        cnt_d   = cnt_q;
        do_pop  = 1'b0;
        do_push = 1'b0;
        if (flush) begin
            ent0_d = '0;
            ent1_d = '0;
            cnt_d  = 2'd0;
        end else begin
            do_pop  = pop && (cnt_q != 2'd0);
            do_push = push && ((cnt_q != 2'd2) || do_pop);
            // Entry 0 is always the head; a pop shifts entry 1 forward.
            if (do_pop) begin
                ent0_d = ent1_q;
                ent1_d = '0;
            end
            if (do_push) begin
                if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && do_pop)) begin
                    ent0_d = push_dat;
                end else begin
                    ent1_d = push_dat;
                end
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count    = cnt_q;
    assign head_vld = (cnt_q != 2'd0);
    assign head_dat = head_vld ? ent0_q : '0;

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction fetch: PC/redirect/halt FSM feeding a 2-entry queue; ihit-to-head latency one cycle.
// Stops requesting when the queue is full; stall holds the head, redirect/halt flush it.
module pipeline_fetch
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] instr_fet,
    output logic [31:0] pc4_fet,
    output logic        fet_valid
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        redir_pc_q, redir_pc_d;
    logic         halt_pend_q, halt_pend_d;

    logic         ren;
    logic         q_push, q_pop, q_flush;
    logic [1:0]   q_count;
    logic         q_head_vld;
    fetch_entry_t q_head;
    fetch_entry_t q_push_dat;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_pc_d  = redir_pc_q;
        halt_pend_d = halt_pend_q;
        ren         = 1'b0;
        q_push      = 1'b0;
        q_pop       = 1'b0;
        q_flush     = 1'b0;
        q_push_dat  = '{instr: iload, pc4: pc_q + 32'd4};
        case (state_q)
            RUN: begin
                ren = (q_count != 2'd2);
                if (halt) begin
                    q_flush = 1'b1;
                    if (ren && !ihit) begin
                        state_d     = DRAIN;
                        halt_pend_d = 1'b1;
                    end else begin
                        state_d = HALTED;
                    end
                end else if (redirect) begin
                    q_flush = 1'b1;
                    if (ren && !ihit) begin
                        redir_pc_d = redirect_pc;
                        state_d    = DRAIN;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else begin
                    q_pop = q_head_vld && !stall;
                    if (ren && ihit) begin
                        q_push = 1'b1;
                        pc_d   = pc_q + 32'd4;
                    end
                end
            end
            DRAIN: begin
                // The stale request stays on the bus until memory answers it.
                ren = 1'b1;
                if (redirect) begin
                    redir_pc_d = redirect_pc;
                end
                if (halt) begin
                    halt_pend_d = 1'b1;
                end
                if (ihit) begin
                    if (halt_pend_q || halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_d    = redirect ? redirect_pc : redir_pc_q;
                        state_d = RUN;
                    end
                end
            end
            HALTED: begin
                ren = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            pc_q        <= PC_INIT;
            redir_pc_q  <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_pc_q  <= redir_pc_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    fetch_queue u_queue (
        .CLK      (CLK),
        .RST      (RST),
        .push     (q_push),
        .push_dat (q_push_dat),
        .pop      (q_pop),
        .flush    (q_flush),
        .count    (q_count),
        .head_vld (q_head_vld),
        .head_dat (q_head)
    );

    assign iREN      = ren && !RST;
    assign iaddr     = pc_q;
    assign fet_valid = q_head_vld && !RST;
    assign instr_fet = fet_valid ? q_head.instr : 32'h0;
    assign pc4_fet   = fet_valid ? q_head.pc4   : 32'h0;

endmodule
